io_controller: RTL and testbench



---
 rtl/io_pkg.sv | 20 ++
 rtl/io_controller_if.sv | 28 ++
 rtl/io_debounce.sv | 57 +++++
 rtl/io_controller.sv | 116 +++++++++++
 tb/tb_io_controller.sv | 211 +++++++++++++++++++++
 5 files changed

// File: rtl/io_pkg.sv
// io_pkg: shared constants for the Risc32 memory-mapped IO controller.
//   - Register indices, selected by io_address[4:2].
//   - Store-size codes, taken from RISC-V funct3.
//   - Debounce limit loaded at reset.
package io_pkg;

  localparam logic [2:0] REG_SW        = 3'd0;
  localparam logic [2:0] REG_BTN_LEVEL = 3'd1;
  localparam logic [2:0] REG_BTN_EVENT = 3'd2;
  localparam logic [2:0] REG_LED       = 3'd3;
  localparam logic [2:0] REG_DB_LIMIT  = 3'd4;

  localparam logic [2:0] SZ_BYTE = 3'b000;
  localparam logic [2:0] SZ_HALF = 3'b001;
  localparam logic [2:0] SZ_WORD = 3'b010;

  // 10 ms at 100 MHz
  localparam int unsigned DB_DEFAULT = 1000000;

endpackage

// File: rtl/io_controller_if.sv
// io_controller_if: Risc32 IO bus as seen by a memory-mapped peripheral.
//   io_address     : byte address
//   io_write_value : store data
//   io_read_value  : load data, combinational in the cycle of io_read_en
//   io_write_en    : one-cycle store strobe
//   io_read_en     : load strobe
//   io_data_size   : RISC-V funct3 access size
// master = CPU side, slave = peripheral side.
interface io_controller_if;

  logic [31:0] io_address;
  logic [31:0] io_write_value;
  logic [31:0] io_read_value;
  logic        io_write_en;
  logic        io_read_en;
  logic [2:0]  io_data_size;

  modport master (
    output io_address, io_write_value, io_write_en, io_read_en, io_data_size,
    input  io_read_value
  );

  modport slave (
    input  io_address, io_write_value, io_write_en, io_read_en, io_data_size,
    output io_read_value
  );

endinterface

// File: rtl/io_debounce.sv
// io_debounce: two-flop synchroniser plus counter debouncer for one input bit.
//   clk, reset : system clock, asynchronous active-high reset
//   i_pin      : raw asynchronous input
//   i_limit    : consecutive mismatching cycles needed to flip (0 behaves as 1)
//   o_level    : debounced level, registered
//   o_rise     : high in the cycle whose clock edge takes o_level from 0 to 1
module io_debounce #(
  parameter int unsigned CNT_W = 20
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_pin,
  input  logic [CNT_W-1:0] i_limit,
  output logic             o_level,
  output logic             o_rise
);

  logic [1:0]       r_sync;
  logic             r_level;
  logic             w_level_nxt;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic [CNT_W-1:0] w_eff_m1;
  logic             w_mis;
  logic             w_hit;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_sync  <= '0;
      r_level <= 1'b0;
      r_cnt   <= '0;
    end else begin
      r_sync  <= {r_sync[0], i_pin};
      r_level <= w_level_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  assign w_eff_m1 = (i_limit == '0) ? '0 : i_limit - CNT_W'(1);
  assign w_mis    = r_sync[1] ^ r_level;
  // >= rather than == so a limit lowered below the running count flips at once.
  assign w_hit    = w_mis & (r_cnt >= w_eff_m1);

  always_comb begin
    w_level_nxt = r_level;
    w_cnt_nxt   = '0;
    if (w_hit) begin
      w_level_nxt = ~r_level;
    end else if (w_mis) begin
      w_cnt_nxt = r_cnt + CNT_W'(1);
    end
  end

  assign o_level = r_level;
  assign o_rise  = w_hit & ~r_level;

endmodule

// File: rtl/io_controller.sv
// io_controller: memory-mapped IO block on the Risc32 IO bus.
//   clk, reset : system clock, asynchronous active-high reset
//   io_bus     : IO bus, slave side (address/data/strobes/size, load data out)
//   sw         : raw switch pins, synchronised only
//   btn        : raw button pins, synchronised and debounced
//   led        : registered LED drive
// Registers (index = io_address[4:2], selected when io_address[31:5] == 0):
//   0 SW (RO), 1 BTN_LEVEL (RO), 2 BTN_EVENT (W1C), 3 LED (RW), 4 DB_LIMIT (RW), 5-7 zero.
module io_controller #(
  parameter int unsigned N_SW       = 16,
  parameter int unsigned N_BTN      = 5,
  parameter int unsigned N_LED      = 16,
  parameter int unsigned CNT_W      = 20,
  parameter int unsigned DB_DEFAULT = io_pkg::DB_DEFAULT
) (
  input  logic                 clk,
  input  logic                 reset,
  io_controller_if.slave       io_bus,
  input  logic [N_SW-1:0]      sw,
  input  logic [N_BTN-1:0]     btn,
  output logic [N_LED-1:0]     led
);

  import io_pkg::*;

  logic [N_SW-1:0]  r_sw_meta;
  logic [N_SW-1:0]  r_sw_sync;
  logic [N_BTN-1:0] w_btn_db;
  logic [N_BTN-1:0] w_btn_rise;
  logic [N_BTN-1:0] r_event;
  logic [N_BTN-1:0] w_event_nxt;
  logic [N_LED-1:0] r_led;
  logic [N_LED-1:0] w_led_nxt;
  logic [CNT_W-1:0] r_limit;
  logic [CNT_W-1:0] w_limit_nxt;
  logic             w_sel;
  logic             w_wr;
  logic [2:0]       w_idx;
  logic [31:0]      w_rdata;

  assign w_sel = (io_bus.io_address[31:5] == 27'd0);
  assign w_idx = io_bus.io_address[4:2];
  assign w_wr  = io_bus.io_write_en & w_sel;

  for (genvar g = 0; g < N_BTN; g++) begin : gen_db
    io_debounce #(
      .CNT_W (CNT_W)
    ) u_db (
      .clk     (clk),
      .reset   (reset),
      .i_pin   (btn[g]),
      .i_limit (r_limit),
      .o_level (w_btn_db[g]),
      .o_rise  (w_btn_rise[g])
    );
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_sw_meta <= '0;
      r_sw_sync <= '0;
      r_event   <= '0;
      r_led     <= '0;
      r_limit   <= CNT_W'(DB_DEFAULT);
    end else begin
      r_sw_meta <= sw;
      r_sw_sync <= r_sw_meta;
      r_event   <= w_event_nxt;
      r_led     <= w_led_nxt;
      r_limit   <= w_limit_nxt;
    end
  end

  always_comb begin
    w_led_nxt   = r_led;
    w_limit_nxt = r_limit;
    w_event_nxt = r_event;
    if (w_wr) begin
      case (w_idx)
        REG_BTN_EVENT: w_event_nxt = r_event & ~io_bus.io_write_value[N_BTN-1:0];
        REG_LED: begin
          case (io_bus.io_data_size)
            SZ_BYTE:          w_led_nxt[7:0] = io_bus.io_write_value[7:0];
            SZ_HALF, SZ_WORD: w_led_nxt = io_bus.io_write_value[N_LED-1:0];
            default:          w_led_nxt = io_bus.io_write_value[N_LED-1:0];
          endcase
        end
        REG_DB_LIMIT:  w_limit_nxt = io_bus.io_write_value[CNT_W-1:0];
        default: ;
      endcase
    end
    // Applied after the clear so a same-cycle rise survives a W1C.
    w_event_nxt = w_event_nxt | w_btn_rise;
  end

  always_comb begin
    w_rdata = '0;
    if (io_bus.io_read_en && w_sel) begin
      case (w_idx)
        REG_SW:        w_rdata[N_SW-1:0]  = r_sw_sync;
        REG_BTN_LEVEL: w_rdata[N_BTN-1:0] = w_btn_db;
        REG_BTN_EVENT: w_rdata[N_BTN-1:0] = r_event;
        REG_LED:       w_rdata[N_LED-1:0] = r_led;
        REG_DB_LIMIT:  w_rdata[CNT_W-1:0] = r_limit;
        default: ;
      endcase
    end
  end

  assign io_bus.io_read_value = w_rdata;
  assign led                  = r_led;

  logic unused_bus;
  assign unused_bus = ^{io_bus.io_address[1:0], io_bus.io_write_value[31:CNT_W]};

endmodule

// File: tb/tb_io_controller.sv
// Directed bench for io_controller: reads push expected data into a scoreboard queue,
// a negedge monitor pops and compares whenever io_read_en is high.
module tb_io_controller;
  import io_pkg::*;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [15:0] sw;
  logic [4:0]  btn;
  logic [15:0] led;

  io_controller_if bus ();

  io_controller #(
    .N_SW       (16),
    .N_BTN      (5),
    .N_LED      (16),
    .CNT_W      (20),
    .DB_DEFAULT (1000000)
  ) dut (
    .clk    (clk),
    .reset  (reset),
    .io_bus (bus),
    .sw     (sw),
    .btn    (btn),
    .led    (led)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] val;
    string       nm;
  } exp_t;

  exp_t sb_q[$];
  exp_t mon_e;
  int   n_checks = 0;
  int   n_errors = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", nm, act, req);
    end
  endtask

  // Monitor: every read cycle pops one expectation; idle cycles must read zero.
  always @(negedge clk) begin
    if (bus.io_read_en) begin
      if (sb_q.size() == 0) begin
        n_checks++;
        n_errors++;
        $display("FAIL unexpected_read: got 0x%08h, expected no read", bus.io_read_value);
      end else begin
        mon_e = sb_q.pop_front();
        chk(mon_e.nm, bus.io_read_value, mon_e.val);
      end
    end else begin
      chk("idle_zero", bus.io_read_value, 32'h0);
    end
  end

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic push_exp(input logic [31:0] v, input string nm);
    exp_t e;
    e.val = v;
    e.nm  = nm;
    sb_q.push_back(e);
  endtask

  task automatic rd(input logic [31:0] a, input logic [31:0] v, input string nm);
    bus.io_address = a;
    bus.io_read_en = 1'b1;
    push_exp(v, nm);
    @(posedge clk);
    #1;
    bus.io_read_en = 1'b0;
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic [2:0] sz);
    bus.io_address     = a;
    bus.io_write_value = d;
    bus.io_data_size   = sz;
    bus.io_write_en    = 1'b1;
    @(posedge clk);
    #1;
    bus.io_write_en = 1'b0;
  endtask

  task automatic rdwr(input logic [31:0] a, input logic [31:0] d, input logic [2:0] sz,
                      input logic [31:0] v, input string nm);
    bus.io_address     = a;
    bus.io_write_value = d;
    bus.io_data_size   = sz;
    bus.io_write_en    = 1'b1;
    bus.io_read_en     = 1'b1;
    push_exp(v, nm);
    @(posedge clk);
    #1;
    bus.io_write_en = 1'b0;
    bus.io_read_en  = 1'b0;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    bus.io_address     = '0;
    bus.io_write_value = '0;
    bus.io_write_en    = 1'b0;
    bus.io_read_en     = 1'b0;
    bus.io_data_size   = SZ_WORD;
    sw  = 16'hA5C3;
    btn = '0;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    idle(2);

    // Reset state
    chk("rst_led_pin", {16'h0, led}, 32'h0);
    rd(32'h00, 32'h0000_A5C3, "rst_sw");
    rd(32'h04, 32'h0, "rst_btn_level");
    rd(32'h08, 32'h0, "rst_btn_event");
    rd(32'h0C, 32'h0, "rst_led");
    rd(32'h10, 32'h000F_4240, "rst_db_limit");
    rd(32'h14, 32'h0, "rst_idx5");
    rd(32'h18, 32'h0, "rst_idx6");
    rd(32'h1C, 32'h0, "rst_idx7");
    rd(32'h03, 32'h0000_A5C3, "sw_addr_lsb_ignored");

    // LED writes and sizes
    wr(32'h0C, 32'h0000_ABCD, SZ_WORD);
    chk("led_word", {16'h0, led}, 32'h0000_ABCD);
    wr(32'h0C, 32'h0000_00FF, SZ_BYTE);
    chk("led_byte", {16'h0, led}, 32'h0000_ABFF);
    rd(32'h0C, 32'h0000_ABFF, "led_readback");
    rdwr(32'h0C, 32'h0000_1234, SZ_HALF, 32'h0000_ABFF, "rdwr_pre_value");
    chk("led_half", {16'h0, led}, 32'h0000_1234);

    // Decode
    rd(32'h20, 32'h0, "dec_0x20");
    rd(32'h8000_000C, 32'h0, "dec_high_bit");
    wr(32'h20, 32'h0000_FFFF, SZ_WORD);
    chk("dec_write_ignored", {16'h0, led}, 32'h0000_1234);
    wr(32'h14, 32'h0000_FFFF, SZ_WORD);
    rd(32'h14, 32'h0, "dec_idx5_write");
    rd(32'h0C, 32'h0000_1234, "led_after_dec");

    // Debounce with limit 4: glitch ignored, held press flips after 2+4 edges
    wr(32'h10, 32'd4, SZ_WORD);
    rd(32'h10, 32'd4, "limit_readback");
    btn[0] = 1'b1;
    repeat (3) rd(32'h04, 32'h0, "glitch_level");
    btn[0] = 1'b0;
    repeat (6) rd(32'h04, 32'h0, "glitch_level_after");
    btn[0] = 1'b1;
    for (int k = 0; k <= 6; k++) rd(32'h04, (k >= 6) ? 32'h1 : 32'h0, "held_level");
    rd(32'h08, 32'h1, "event_b0");

    // W1C and set-wins
    btn[1] = 1'b1;
    idle(8);
    rd(32'h08, 32'h3, "event_b01");
    wr(32'h08, 32'h1, SZ_BYTE);
    rd(32'h08, 32'h2, "w1c_b0");
    btn[2] = 1'b1;
    idle(5);
    wr(32'h08, 32'h4, SZ_WORD);
    rd(32'h08, 32'h6, "set_wins_b2");
    rd(32'h04, 32'h7, "level_b012");
    wr(32'h08, 32'h4, SZ_WORD);
    rd(32'h08, 32'h2, "w1c_b2");

    // Reset mid-count with btn[1] held
    btn = '0;
    idle(8);
    rd(32'h04, 32'h0, "level_released");
    wr(32'h10, 32'd100, SZ_WORD);
    btn[1] = 1'b1;
    idle(50);
    reset = 1'b1;
    rd(32'h10, 32'h000F_4240, "rst2_db_limit");
    rd(32'h04, 32'h0, "rst2_level");
    chk("rst2_led", {16'h0, led}, 32'h0);
    idle(1);
    reset = 1'b0;
    wr(32'h10, 32'd100, SZ_WORD);
    idle(100);
    rd(32'h04, 32'h0, "rerun_level_101");
    rd(32'h04, 32'h2, "rerun_level_102");
    rd(32'h08, 32'h2, "rerun_event");

    idle(2);
    chk("sb_drained", 32'(sb_q.size()), 32'h0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
